// File: rtl/act_quant_pack.sv
// Activation quantiser: optional ReLU, rounding right shift and int8 saturation on 32 lanes.
// Two 256-bit beats are packed per 512-bit output word; ACT_QUANT_STATS_EN adds a saturation counter.
module act_quant_pack #(
    parameter int LANES = 32,
    parameter int IN_W  = 16,
    parameter int OUT_W = 8
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       cfg_relu_en,
    input  logic [3:0]                 cfg_shift,
    input  logic [LANES*IN_W-1:0]      in_data,
    input  logic                       in_valid,
    input  logic                       in_last,
    output logic                       in_ready,
    output logic [2*LANES*OUT_W-1:0]   out_data,
    output logic                       out_valid,
    output logic                       out_half,
    output logic                       out_last,
    input  logic                       out_ready
`ifdef ACT_QUANT_STATS_EN
    ,
    output logic [31:0]                sat_cnt
`endif
);

    localparam int BEAT_W = LANES * OUT_W;
    localparam logic signed [IN_W:0] ONE  = (IN_W+1)'(1);
    localparam logic signed [IN_W:0] MAXV = (IN_W+1)'((1 << (OUT_W-1)) - 1);
    localparam logic signed [IN_W:0] MINV = (IN_W+1)'(-(1 << (OUT_W-1)));

    typedef enum logic {LO_WAIT, HI_WAIT} pack_state_t;

    pack_state_t               state;
    logic                      s1_valid;
    logic                      s1_last;
    logic [BEAT_W-1:0]         s1_data;
    logic [BEAT_W-1:0]         low_half;
    logic [BEAT_W-1:0]         q_data;
    logic signed [IN_W:0]      lane_r [LANES];
    logic                      out_free;
    logic                      s1_adv;
    logic                      in_fire;

    // One extra bit of headroom keeps x + 2^(s-1) from overflowing before the shift.
    function automatic logic signed [IN_W:0] round_lane(input logic [IN_W-1:0] x_in,
                                                       input logic relu,
                                                       input logic [3:0] s);
        logic signed [IN_W:0] x;
        logic signed [IN_W:0] half;
        x = $signed({x_in[IN_W-1], x_in});
        if (relu && x_in[IN_W-1])
            x = '0;
        half = (s == 4'd0) ? '0 : (ONE <<< (s - 4'd1));
        return (x + half) >>> s;
    endfunction

    always_comb begin
        for (int i = 0; i < LANES; i++)
            lane_r[i] = round_lane(in_data[i*IN_W +: IN_W], cfg_relu_en, cfg_shift);
    end

    always_comb begin
        q_data = '0;
        for (int i = 0; i < LANES; i++) begin
            if (lane_r[i] > MAXV)
                q_data[i*OUT_W +: OUT_W] = MAXV[OUT_W-1:0];
            else if (lane_r[i] < MINV)
                q_data[i*OUT_W +: OUT_W] = MINV[OUT_W-1:0];
            else
                q_data[i*OUT_W +: OUT_W] = lane_r[i][OUT_W-1:0];
        end
    end

    // A non-last beat in LO_WAIT only moves into the low-half register, so it never waits on the output.
    assign out_free = !out_valid || out_ready;
    assign s1_adv   = s1_valid && (((state == LO_WAIT) && !s1_last) || out_free);
    assign in_ready = !rst && (!s1_valid || s1_adv);
    assign in_fire  = in_valid && in_ready;

    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= LO_WAIT;
            s1_valid  <= 1'b0;
            s1_last   <= 1'b0;
            s1_data   <= '0;
            low_half  <= '0;
            out_valid <= 1'b0;
            out_data  <= '0;
            out_half  <= 1'b0;
            out_last  <= 1'b0;
        end else begin
            if (out_valid && out_ready)
                out_valid <= 1'b0;

            if (s1_adv) begin
                case (state)
                    LO_WAIT: begin
                        if (s1_last) begin
                            out_data  <= {{BEAT_W{1'b0}}, s1_data};
                            out_valid <= 1'b1;
                            out_half  <= 1'b1;
                            out_last  <= 1'b1;
                        end else begin
                            low_half <= s1_data;
                            state    <= HI_WAIT;
                        end
                    end
                    HI_WAIT: begin
                        out_data  <= {s1_data, low_half};
                        out_valid <= 1'b1;
                        out_half  <= 1'b0;
                        out_last  <= s1_last;
                        state     <= LO_WAIT;
                    end
                    default: state <= LO_WAIT;
                endcase
            end

            if (in_fire) begin
                s1_data  <= q_data;
                s1_last  <= in_last;
                s1_valid <= 1'b1;
            end else if (s1_adv) begin
                s1_valid <= 1'b0;
            end
        end
    end

`ifdef ACT_QUANT_STATS_EN
    logic [LANES-1:0] q_sat;

    always_comb begin
        q_sat = '0;
        for (int i = 0; i < LANES; i++)
            q_sat[i] = (lane_r[i] > MAXV) || (lane_r[i] < MINV);
    end

    always_ff @(posedge clk) begin
        if (rst)
            sat_cnt <= '0;
        else if (in_fire)
            sat_cnt <= sat_cnt + 32'($countones(q_sat));
    end
`endif

endmodule

// File: tb/tb_act_quant_pack.sv
// Testbench for act_quant_pack: directed steps with a scoreboard of expected output words.
// Compile with ACT_QUANT_STATS_EN to also exercise the saturation counter.
module tb_act_quant_pack;

    logic         clk = 1'b0;
    logic         rst = 1'b1;
    logic         cfg_relu_en = 1'b0;
    logic [3:0]   cfg_shift = 4'd0;
    logic [511:0] in_data = '0;
    logic         in_valid = 1'b0;
    logic         in_last = 1'b0;
    logic         in_ready;
    logic [511:0] out_data;
    logic         out_valid;
    logic         out_half;
    logic         out_last;
    logic         out_ready = 1'b1;
`ifdef ACT_QUANT_STATS_EN
    logic [31:0]  sat_cnt;
`endif

    typedef struct {
        logic [511:0] data;
        logic         half;
        logic         last;
    } exp_word_t;

    exp_word_t    sb[$];
    logic [255:0] model_low;
    bit           model_have_low = 0;
    bit           stall_seen = 0;
    int           checks = 0;
    int           failures = 0;
    int           words_expected = 0;
    int           words_seen = 0;
    bit           hold_prev = 0;
    logic [511:0] prev_data;
    logic         prev_half;
    logic         prev_last;

    act_quant_pack dut (
        .clk(clk), .rst(rst), .cfg_relu_en(cfg_relu_en), .cfg_shift(cfg_shift),
        .in_data(in_data), .in_valid(in_valid), .in_last(in_last), .in_ready(in_ready),
        .out_data(out_data), .out_valid(out_valid), .out_half(out_half),
        .out_last(out_last), .out_ready(out_ready)
`ifdef ACT_QUANT_STATS_EN
        , .sat_cnt(sat_cnt)
`endif
    );

    always #5 clk = ~clk;

    task automatic check_output(input string tag, input logic [511:0] obs, input logic [511:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("[TB] FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Reference quantiser written with floor division rather than shifts.
    function automatic logic [255:0] model_beat(input logic [511:0] d, input logic relu, input int s);
        logic [255:0] res;
        int x, v, dv, r;
        res = '0;
        for (int i = 0; i < 32; i++) begin
            x = int'($signed(d[16*i +: 16]));
            if (relu && x < 0) x = 0;
            dv = 1 << s;
            v  = (s == 0) ? x : x + dv / 2;
            r  = (v >= 0) ? v / dv : -((-v + dv - 1) / dv);
            if (r > 127) r = 127;
            if (r < -128) r = -128;
            res[8*i +: 8] = 8'(r);
        end
        return res;
    endfunction

    function automatic logic [511:0] make_beat(input int a, input int b, input int c, input int d);
        logic [511:0] res;
        int vals [4];
        vals = '{a, b, c, d};
        res = '0;
        for (int i = 0; i < 32; i++)
            res[16*i +: 16] = 16'(vals[i % 4]);
        return res;
    endfunction

    task automatic model_accept(input logic [511:0] d, input logic last, input logic relu, input int s);
        logic [255:0] q;
        exp_word_t w;
        q = model_beat(d, relu, s);
        if (!model_have_low && !last) begin
            model_low = q;
            model_have_low = 1;
            return;
        end
        if (!model_have_low) begin
            w.data = {256'd0, q};
            w.half = 1'b1;
            w.last = 1'b1;
        end else begin
            w.data = {q, model_low};
            w.half = 1'b0;
            w.last = last;
            model_have_low = 0;
        end
        sb.push_back(w);
        words_expected++;
    endtask

    task automatic apply_stimulus(input logic [511:0] d, input logic last, input logic relu, input int s);
        bit accepted;
        in_data = d;
        in_last = last;
        cfg_relu_en = relu;
        cfg_shift = 4'(s);
        in_valid = 1'b1;
        accepted = 0;
        for (int c = 0; c < 200 && !accepted; c++) begin
            @(negedge clk);
            accepted = in_ready;
            if (!accepted) stall_seen = 1;
            @(posedge clk);
            #1;
        end
        in_valid = 1'b0;
        check_output("accept_timeout", 512'(accepted), 512'd1);
        if (accepted) model_accept(d, last, relu, s);
    endtask

    task automatic idle(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic do_reset();
        rst = 1'b1;
        sb.delete();
        model_have_low = 0;
        idle(1);
        @(negedge clk);
        check_output("in_ready_in_reset", 512'(in_ready), 512'd0);
        @(posedge clk);
        #1;
        rst = 1'b0;
    endtask

    // Checks a just-completed word appears exactly two cycles after its completing beat was accepted.
    task automatic check_latency(input string tag, input int bit_off, input logic [31:0] exp);
        @(negedge clk);
        check_output({tag, "_t1_valid"}, 512'(out_valid), 512'd0);
        @(negedge clk);
        check_output({tag, "_t2_valid"}, 512'(out_valid), 512'd1);
        check_output({tag, "_bytes"}, 512'(out_data[bit_off +: 32]), 512'(exp));
    endtask

    // Scoreboard side: pops on each output handshake and checks that a stalled word holds steady.
    always @(negedge clk) begin
        exp_word_t w;
        if (rst) begin
            hold_prev = 0;
        end else begin
            if (hold_prev) begin
                check_output("stall_data_stable", out_data, prev_data);
                check_output("stall_flags_stable", 512'({out_valid, out_half, out_last}),
                             512'({1'b1, prev_half, prev_last}));
            end
            hold_prev = out_valid && !out_ready;
            prev_data = out_data;
            prev_half = out_half;
            prev_last = out_last;
            if (out_valid && out_ready) begin
                words_seen++;
                if (sb.size() == 0) begin
                    check_output("unexpected_word", out_data, 512'd0);
                end else begin
                    w = sb.pop_front();
                    check_output("word_data", out_data, w.data);
                    check_output("word_half", 512'(out_half), 512'(w.half));
                    check_output("word_last", 512'(out_last), 512'(w.last));
                end
            end
        end
    end

    initial begin
        logic [511:0] rb;
        int n;

        $display("[TB] reset state");
        idle(2);
        @(negedge clk);
        check_output("rst_in_ready", 512'(in_ready), 512'd0);
        check_output("rst_out_valid", 512'(out_valid), 512'd0);
        check_output("rst_out_data", out_data, 512'd0);
        check_output("rst_out_flags", 512'({out_half, out_last}), 512'd0);
        @(posedge clk);
        #1;
        rst = 1'b0;
        @(negedge clk);
        check_output("post_rst_in_ready", 512'(in_ready), 512'd1);
`ifdef ACT_QUANT_STATS_EN
        check_output("sat_cnt_reset", 512'(sat_cnt), 512'd0);
`endif
        idle(1);

        $display("[TB] saturation basics, two beats");
        apply_stimulus(make_beat(100, -100, 300, -300), 1'b0, 1'b0, 0);
        apply_stimulus(make_beat(300, -300, 100, -100), 1'b0, 1'b0, 0);
        check_latency("sat_word", 0, 32'h807F9C64);
        idle(3);

        $display("[TB] rounding at shift 1");
        apply_stimulus(make_beat(7, 5, -5, -6), 1'b0, 1'b0, 1);
        apply_stimulus(make_beat(1, -1, 3, -3), 1'b1, 1'b0, 1);
        check_latency("round_word", 0, 32'hFDFE0304);
        idle(3);

        $display("[TB] relu and large shift");
        apply_stimulus(make_beat(-1, -32768, 5, 0), 1'b0, 1'b1, 0);
        apply_stimulus(make_beat(32767, -1, 384, -384), 1'b1, 1'b1, 8);
        check_latency("relu_word", 256, 32'h0002007F);
        idle(3);

        $display("[TB] A B C(last) tile flush");
        apply_stimulus(make_beat(1, 2, 3, 4), 1'b0, 1'b0, 0);
        apply_stimulus(make_beat(5, 6, 7, 8), 1'b0, 1'b0, 0);
        apply_stimulus(make_beat(9, 10, 11, 12), 1'b1, 1'b0, 0);
        idle(4);

        $display("[TB] backpressure during a 6-beat stream");
        stall_seen = 0;
        fork
            begin
                for (int i = 0; i < 6; i++)
                    apply_stimulus(make_beat(20 * i, -7 * i, 1000 * i, 3 - i), 1'b0, 1'b0, 2);
            end
            begin
                idle(3);
                out_ready = 1'b0;
                idle(10);
                out_ready = 1'b1;
            end
        join
        check_output("in_ready_dropped", 512'(stall_seen), 512'd1);
        idle(6);

        $display("[TB] reset while low half is held");
        apply_stimulus(make_beat(-50, 50, -60, 60), 1'b0, 1'b0, 0);
        idle(2);
        do_reset();
        apply_stimulus(make_beat(11, 22, 33, 44), 1'b0, 1'b0, 0);
        apply_stimulus(make_beat(-11, -22, -33, -44), 1'b1, 1'b0, 0);
        idle(4);

`ifdef ACT_QUANT_STATS_EN
        $display("[TB] saturation counter");
        do_reset();
        apply_stimulus(make_beat(32767, 32767, 32767, 32767), 1'b1, 1'b0, 0);
        idle(2);
        check_output("sat_cnt_32", 512'(sat_cnt), 512'd32);
        apply_stimulus(make_beat(-32768, -1, 200, 5), 1'b1, 1'b1, 0);
        idle(2);
        check_output("sat_cnt_relu", 512'(sat_cnt), 512'd40);
        idle(2);
`endif

        $display("[TB] random stream with random out_ready");
        fork
            begin
                for (int i = 0; i < 12; i++) begin
                    for (int k = 0; k < 16; k++) rb[32*k +: 32] = $urandom;
                    apply_stimulus(rb, (i == 4 || i == 11) ? 1'b1 : 1'b0,
                                   1'($urandom_range(0, 1)), int'($urandom_range(0, 15)));
                end
            end
            begin
                for (int c = 0; c < 40; c++) begin
                    out_ready = 1'($urandom_range(0, 1));
                    idle(1);
                end
                out_ready = 1'b1;
            end
        join
        out_ready = 1'b1;

        n = 0;
        while (sb.size() != 0 && n < 500) begin
            idle(1);
            n++;
        end
        idle(2);
        check_output("scoreboard_drained", 512'(sb.size()), 512'd0);
        check_output("word_count", 512'(words_seen), 512'(words_expected));

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
